pattern_frame_ctrl: RTL and testbench

//  Frame timing controller for the pattern generator datapath.

---
 rtl/pattern_frame_if.sv | 32 +++
 rtl/pattern_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_pattern_frame_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_frame_if.sv
// Control, status and line-counter hookup between the frame controller and its neighbours.
// The slave side belongs to pattern_frame_ctrl. The master side drives start/stop/mode and returns end_frame.
interface pattern_frame_if #(
  parameter int PIX_PER_LINE = 32,
  parameter int FRAME_CNT_W  = 8
);
  localparam int PIX_W = $clog2(PIX_PER_LINE);

  logic                   start;
  logic                   stop;
  logic                   continuous;
  logic [2:0]             pat_sel_in;
  logic                   end_frame;
  logic                   line_cnt_enb;
  logic                   new_line;
  logic                   pix_valid;
  logic [PIX_W-1:0]       pix_x;
  logic [2:0]             pat_sel;
  logic                   busy;
  logic                   frame_done;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output start, stop, continuous, pat_sel_in, end_frame,
    input  line_cnt_enb, new_line, pix_valid, pix_x, pat_sel, busy, frame_done, frame_cnt
  );

  modport slave (
    input  start, stop, continuous, pat_sel_in, end_frame,
    output line_cnt_enb, new_line, pix_valid, pix_x, pat_sel, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/pattern_frame_ctrl.sv
// Frame timing controller: sequences pixels within a line and lines within a frame.
// It drives an external line counter, and every output comes directly from a flop.
module pattern_frame_ctrl #(
  parameter int PIX_PER_LINE = 32,
  parameter int HBLANK       = 4,
  parameter int FRAME_CNT_W  = 8
) (
  input logic            clk,
  input logic            rst,
  pattern_frame_if.slave bus
);
  localparam int PIX_W = $clog2(PIX_PER_LINE);
  localparam int HB_W  = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_LINE - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HBLANK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_FRAME_END
  } state_t;

  state_t                 state, state_nxt;
  logic [HB_W-1:0]        hb_cnt, hb_cnt_nxt;
  logic                   stop_pend, stop_pend_nxt;
  logic                   line_cnt_enb, line_cnt_enb_nxt;
  logic                   new_line, new_line_nxt;
  logic                   pix_valid, pix_valid_nxt;
  logic [PIX_W-1:0]       pix_x, pix_x_nxt;
  logic [2:0]             pat_sel, pat_sel_nxt;
  logic                   busy, busy_nxt;
  logic                   frame_done, frame_done_nxt;
  logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_nxt;

  // The next value of each output is computed here so that the flops present it in the cycle the new state begins.
  always_comb begin
    state_nxt        = state;
    hb_cnt_nxt       = hb_cnt;
    stop_pend_nxt    = stop_pend;
    line_cnt_enb_nxt = line_cnt_enb;
    new_line_nxt     = 1'b0;
    pix_valid_nxt    = 1'b0;
    pix_x_nxt        = pix_x;
    pat_sel_nxt      = pat_sel;
    frame_done_nxt   = 1'b0;
    frame_cnt_nxt    = frame_cnt;

    if (state != S_IDLE && bus.stop) begin
      stop_pend_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt        = S_ACTIVE;
          pix_x_nxt        = '0;
          pix_valid_nxt    = 1'b1;
          pat_sel_nxt      = bus.pat_sel_in;
          line_cnt_enb_nxt = 1'b1;
          stop_pend_nxt    = bus.stop;
        end
      end

      S_ACTIVE: begin
        if (pix_x == PIX_LAST) begin
          state_nxt  = S_HBLANK;
          pix_x_nxt  = '0;
          hb_cnt_nxt = '0;
        end else begin
          pix_valid_nxt = 1'b1;
          pix_x_nxt     = pix_x + 1'b1;
        end
      end

      S_HBLANK: begin
        if (hb_cnt == HB_LAST) begin
          if (!bus.end_frame) begin
            state_nxt     = S_ACTIVE;
            new_line_nxt  = 1'b1;
            pix_valid_nxt = 1'b1;
            pix_x_nxt     = '0;
          end else begin
            state_nxt        = S_FRAME_END;
            line_cnt_enb_nxt = 1'b0;
            frame_done_nxt   = 1'b1;
            frame_cnt_nxt    = frame_cnt + 1'b1;
          end
        end else begin
          hb_cnt_nxt = hb_cnt + 1'b1;
        end
      end

      S_FRAME_END: begin
        // A pending stop always wins over continuous mode.
        if (stop_pend || !bus.continuous) begin
          state_nxt     = S_IDLE;
          stop_pend_nxt = 1'b0;
        end else begin
          state_nxt        = S_ACTIVE;
          line_cnt_enb_nxt = 1'b1;
          pat_sel_nxt      = bus.pat_sel_in;
          pix_valid_nxt    = 1'b1;
          pix_x_nxt        = '0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers. Reset is asynchronous and may land mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      hb_cnt       <= '0;
      stop_pend    <= 1'b0;
      line_cnt_enb <= 1'b0;
      new_line     <= 1'b0;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pat_sel      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      hb_cnt       <= hb_cnt_nxt;
      stop_pend    <= stop_pend_nxt;
      line_cnt_enb <= line_cnt_enb_nxt;
      new_line     <= new_line_nxt;
      pix_valid    <= pix_valid_nxt;
      pix_x        <= pix_x_nxt;
      pat_sel      <= pat_sel_nxt;
      busy         <= busy_nxt;
      frame_done   <= frame_done_nxt;
      frame_cnt    <= frame_cnt_nxt;
    end
  end

  assign bus.line_cnt_enb = line_cnt_enb;
  assign bus.new_line     = new_line;
  assign bus.pix_valid    = pix_valid;
  assign bus.pix_x        = pix_x;
  assign bus.pat_sel      = pat_sel;
  assign bus.busy         = busy;
  assign bus.frame_done   = frame_done;
  assign bus.frame_cnt    = frame_cnt;
endmodule

// File: tb/tb_pattern_frame_ctrl.sv
// Directed bench for pattern_frame_ctrl. Each DUT gets a 24-line counter model.
// A second DUT instance uses a 2-bit frame counter.
module tb_pattern_frame_ctrl;
  logic clk;
  logic rst;

  pattern_frame_if #(.PIX_PER_LINE(32), .FRAME_CNT_W(8)) bus ();
  pattern_frame_if #(.PIX_PER_LINE(32), .FRAME_CNT_W(2)) bus2 ();

  pattern_frame_ctrl #(.PIX_PER_LINE(32), .HBLANK(4), .FRAME_CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pattern_frame_ctrl #(.PIX_PER_LINE(32), .HBLANK(4), .FRAME_CNT_W(2)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  logic [4:0] lineCnt;
  logic [4:0] lineCnt2;
  int checkCount = 0;
  int passCount  = 0;
  int busyCycles = 0;
  int newLineCount = 0;
  int pixValidCount = 0;
  int frameDoneCount = 0;
  int newLineErr = 0;
  logic prevNewLine = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line counter models: a low enable clears the count, and new_line advances it.
  always @(posedge clk) begin
    if (!bus.line_cnt_enb) lineCnt <= 5'd0;
    else if (bus.new_line) lineCnt <= lineCnt + 5'd1;
    if (!bus2.line_cnt_enb) lineCnt2 <= 5'd0;
    else if (bus2.new_line) lineCnt2 <= lineCnt2 + 5'd1;
  end

  assign bus.end_frame  = (lineCnt == 5'd23);
  assign bus2.end_frame = (lineCnt2 == 5'd23);

  // Cumulative activity counters and the new_line pulse rule, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.busy) busyCycles <= busyCycles + 1;
    if (bus.new_line) newLineCount <= newLineCount + 1;
    if (bus.pix_valid) pixValidCount <= pixValidCount + 1;
    if (bus.frame_done) frameDoneCount <= frameDoneCount + 1;
    if (bus.new_line && (prevNewLine || !bus.line_cnt_enb)) newLineErr <= newLineErr + 1;
    prevNewLine <= bus.new_line;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic c, input logic [2:0] p);
    bus.start = s;
    bus.stop = st;
    bus.continuous = c;
    bus.pat_sel_in = p;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDone(input int which, input int limit, output int steps);
    bit ok;
    ok = 1'b0;
    steps = 0;
    while (steps < limit && !ok) begin
      @(negedge clk);
      steps++;
      if ((which == 0) ? bus.frame_done : bus2.frame_done) ok = 1'b1;
    end
    if (!ok) checkOutput("frame_done_timeout", 32'(steps), 32'(limit + 1));
  endtask

  task automatic waitIdle(input int limit);
    int steps;
    steps = 0;
    while (steps < limit && bus.busy) begin
      @(negedge clk);
      steps++;
    end
    if (bus.busy) checkOutput("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int total;
    int snapBusy, snapNewLine, snapPix, snapDone;
    int expSeq[5];
    bit found;
    expSeq = '{1, 2, 3, 0, 1};

    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0; bus.pat_sel_in = 3'd0;
    bus2.start = 1'b0; bus2.stop = 1'b0; bus2.continuous = 1'b0; bus2.pat_sel_in = 3'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_enb", 32'(bus.line_cnt_enb), 32'd0);
    checkOutput("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    checkOutput("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    checkOutput("rst_frame_cnt2", 32'(bus2.frame_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-shot frame.
    snapBusy = busyCycles; snapNewLine = newLineCount; snapPix = pixValidCount; snapDone = frameDoneCount;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd5);
    checkOutput("t1_busy_start", 32'(bus.busy), 32'd1);
    checkOutput("t1_enb_start", 32'(bus.line_cnt_enb), 32'd1);
    checkOutput("t1_pix_x0", 32'(bus.pix_x), 32'd0);
    checkOutput("t1_pix_valid", 32'(bus.pix_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd5);
    checkOutput("t1_pix_x1", 32'(bus.pix_x), 32'd1);
    waitIdle(2000);
    repeat (3) @(negedge clk);
    checkOutput("t1_busy_cycles", 32'(busyCycles - snapBusy), 32'd865);
    checkOutput("t1_new_lines", 32'(newLineCount - snapNewLine), 32'd23);
    checkOutput("t1_pix_valid_cycles", 32'(pixValidCount - snapPix), 32'd768);
    checkOutput("t1_frame_done", 32'(frameDoneCount - snapDone), 32'd1);
    checkOutput("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    checkOutput("t1_pat_sel", 32'(bus.pat_sel), 32'd5);
    checkOutput("t1_enb_idle", 32'(bus.line_cnt_enb), 32'd0);

    // Continuous frames with a pattern change mid-frame and a stop in frame 3.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
    checkOutput("t3_pat_sel_start", 32'(bus.pat_sel), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2);
    repeat (98) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd6);
    checkOutput("t3_pat_sel_hold", 32'(bus.pat_sel), 32'd2);
    waitDone(0, 2000, n);
    checkOutput("t3_pat_sel_at_fe", 32'(bus.pat_sel), 32'd2);
    checkOutput("t2_enb_at_fe", 32'(bus.line_cnt_enb), 32'd0);
    checkOutput("t2_frame_cnt1", 32'(bus.frame_cnt), 32'd1);
    @(negedge clk);
    checkOutput("t3_pat_sel_new", 32'(bus.pat_sel), 32'd6);
    checkOutput("t2_restart_pix_x", 32'(bus.pix_x), 32'd0);
    checkOutput("t2_restart_busy", 32'(bus.busy), 32'd1);
    waitDone(0, 2000, n);
    checkOutput("t2_spacing12", 32'(n + 1), 32'd865);
    checkOutput("t2_frame_cnt2", 32'(bus.frame_cnt), 32'd2);
    repeat (400) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd6);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd6);
    waitDone(0, 2000, n);
    checkOutput("t2_spacing23", 32'(n + 402), 32'd865);
    checkOutput("t2_frame_cnt3", 32'(bus.frame_cnt), 32'd3);
    @(negedge clk);
    checkOutput("t2_idle_after_stop", 32'(bus.busy), 32'd0);

    // Reset at line 10, pixel 17.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (lineCnt == 5'd10 && bus.pix_x == 5'd17 && bus.pix_valid) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("t4_reached_l10_p17", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t4_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("t4_rst_pix_x", 32'(bus.pix_x), 32'd0);
    checkOutput("t4_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    checkOutput("t4_rst_enb", 32'(bus.line_cnt_enb), 32'd0);
    checkOutput("t4_rst_pat_sel", 32'(bus.pat_sel), 32'd0);
    checkOutput("t4_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_line_cnt_cleared", 32'(lineCnt), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd4);
    checkOutput("t4_restart_pix_x", 32'(bus.pix_x), 32'd0);
    checkOutput("t4_restart_line", 32'(lineCnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd4);
    waitDone(0, 2000, n);
    checkOutput("t4_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    @(negedge clk);

    // Start and stop together in continuous mode, then a start while busy.
    snapBusy = busyCycles; snapDone = frameDoneCount;
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd3);
    checkOutput("t5_busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    repeat (200) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd7);
    checkOutput("t5_pix_x_unaffected", 32'(bus.pix_x), 32'd22);
    checkOutput("t5_pat_sel_unaffected", 32'(bus.pat_sel), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7);
    waitIdle(2000);
    repeat (5) @(negedge clk);
    checkOutput("t5_one_frame", 32'(frameDoneCount - snapDone), 32'd1);
    checkOutput("t5_busy_cycles", 32'(busyCycles - snapBusy), 32'd865);
    checkOutput("t5_stays_idle", 32'(bus.busy), 32'd0);
    checkOutput("t5_frame_cnt", 32'(bus.frame_cnt), 32'd2);

    // Two-bit frame counter wraps without a flag.
    bus2.continuous = 1'b1;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      waitDone(1, 2000, n);
      checkOutput($sformatf("t6_frame_cnt_%0d", i), 32'(bus2.frame_cnt), 32'(expSeq[i]));
    end
    bus2.stop = 1'b1;
    @(negedge clk);
    bus2.stop = 1'b0;
    total = 0;
    while (total < 2000 && bus2.busy) begin
      @(negedge clk);
      total++;
    end
    checkOutput("t6_idle", 32'(bus2.busy), 32'd0);

    checkOutput("new_line_rule", 32'(newLineErr), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
